rp_sd_arbiter: RTL and testbench
================================

// Module: rp_sd_arbiter
// PURPOSE
//  Parametrised arbiter sharing one SD sector engine among NUM_DRV RPxx drives.
//  Replaces fixed 8-drive scan logic: fair round-robin grant, per-request op/LSA
//  latching, completion handshake, watchdog timeout and controller-clear abort.
//  Sits between the RPXX drive array and the SD controller in the RP disk block.
// PARAMETERS
//  NUM_DRV      8        number of drives arbitrated (1..16)
//  OP_W         3        SD operation code width
//  LSA_W        21       linear sector address width
//  TIMEOUT      2**22    cycles allowed per SD operation; 0 disables watchdog
//  SCAN_W       derived  max(1,$clog2(NUM_DRV)), not overridable
// PORTS
//  clk       in   1              system clock
//  rst       in   1              synchronous active-high reset
//  clr       in   1              massbus INIT; synchronous clear/abort
//  drvREQ    in   NUM_DRV        per-drive SD request (level)
//  drvSDOP   in   NUM_DRV*OP_W   per-drive op, drive n at [n*OP_W +: OP_W]
//  drvSDLSA  in   NUM_DRV*LSA_W  per-drive LSA, drive n at [n*LSA_W +: LSA_W]
//  drvACK    out  NUM_DRV        one-cycle completion pulse to granted drive
//  drvTMO    out  NUM_DRV        one-cycle timeout pulse, coincident with drvACK
//  sdREQ     out  1              request to SD engine (level, held until done)
//  sdOP      out  OP_W           latched op of granted drive
//  sdLSA     out  LSA_W          latched LSA of granted drive
//  sdSCAN    out  SCAN_W         index of granted drive
//  sdACK     in   1              SD engine completion pulse
//  sdABORT   out  1              one-cycle pulse: operation aborted by clr
//  arbBUSY   out  1              high in GRANT/WAIT/DONE
// BEHAVIOUR
//  Reset: every output 0; state IDLE; round-robin pointer ptr=0; timer=0.
//  clr: same effect as rst, except sdABORT=1 for one cycle if state was WAIT.
//  rst has priority over clr; clr has priority over all other events.
//  States:
//   IDLE : if |drvREQ, grant first n with drvREQ[n] searching ptr, ptr+1, ...
//          mod NUM_DRV; latch sdSCAN=n, sdOP, sdLSA; -> WAIT. Else stay.
//          Latency: drvREQ seen cycle t -> sdREQ=1 cycle t+1.
//   WAIT : sdREQ=1; sdOP/sdLSA/sdSCAN frozen (drive input changes ignored).
//          timer increments each cycle from 0.
//          sdACK=1 -> drvACK[sdSCAN]=1 next cycle, sdREQ=0, -> DONE.
//          else TIMEOUT!=0 and timer==TIMEOUT-1 -> drvACK[sdSCAN]=1 and
//          drvTMO[sdSCAN]=1 next cycle, sdREQ=0, -> DONE.
//          sdACK and timeout in the same cycle: sdACK wins, no drvTMO.
//   DONE : one cycle; ptr <= (sdSCAN==NUM_DRV-1) ? 0 : sdSCAN+1; timer=0;
//          drvREQ ignored this cycle so granted drive can drop its request;
//          -> IDLE.
//  sdACK outside WAIT is ignored. drvACK/drvTMO are one-hot or zero.
//  Request dropped during WAIT: operation still completes; drvACK still sent.
//  Minimum turnaround: grant-to-next-grant = WAIT cycles + 2.
//  Pointer wrap is explicit for non-power-of-two NUM_DRV (no modulo aliasing).
//  NUM_DRV=1: sdSCAN width 1, always 0; ptr stays 0.
//  timer width $clog2(TIMEOUT+1); saturates, never wraps.
// TESTING
//  1 reset: rst=1 2 cycles with drvREQ=8'hFF -> all outputs 0, state IDLE.
//  2 single: drvREQ[3]=1, OP=3'd2, LSA=21'h1234; sdACK after 10 cycles ->
//    sdREQ cycle t+1, sdSCAN=3, sdLSA=21'h1234, drvACK=8'h08 one cycle.
//  3 fairness: drvREQ=8'hFF held, sdACK 5 cycles after each sdREQ -> grant
//    order 0,1,...,7,0; NUM_DRV=5 build -> order 0..4,0 (wrap check).
//  4 timeout: TIMEOUT=16, drvREQ[5], no sdACK -> drvACK[5]=drvTMO[5]=1 exactly
//    16 cycles after sdREQ rises; sdACK on cycle 16 instead -> drvTMO=0.
//  5 abort: clr during WAIT for drive 2 -> sdABORT=1 one cycle, sdREQ=0,
//    drvACK=0, next grant starts search at drive 0.
//  6 freeze: change drvSDLSA[2] during WAIT -> sdLSA unchanged until next grant.

Source files
------------

// File: rtl/rp_sd_arbiter.sv
// Round-robin arbiter sharing one SD sector engine among NUM_DRV drives.
// Latches op/LSA per grant, with completion handshake, watchdog and clear/abort.
module rp_sd_arbiter #(
  parameter int NUM_DRV = 8,
  parameter int OP_W    = 3,
  parameter int LSA_W   = 21,
  parameter int TIMEOUT = 2**22,
  localparam int SCAN_W = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_DRV-1:0]       drvREQ,
  input  logic [NUM_DRV*OP_W-1:0]  drvSDOP,
  input  logic [NUM_DRV*LSA_W-1:0] drvSDLSA,
  output logic [NUM_DRV-1:0]       drvACK,
  output logic [NUM_DRV-1:0]       drvTMO,
  output logic                     sdREQ,
  output logic [OP_W-1:0]          sdOP,
  output logic [LSA_W-1:0]         sdLSA,
  output logic [SCAN_W-1:0]        sdSCAN,
  input  logic                     sdACK,
  output logic                     sdABORT,
  output logic                     arbBUSY
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST =
    TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SCAN_W-1:0] LAST_DRV = SCAN_W'(NUM_DRV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [SCAN_W-1:0]   ptr_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [OP_W-1:0]     op_q;
  logic [LSA_W-1:0]    lsa_q;
  logic [TMR_W-1:0]    timer_q;
  logic [NUM_DRV-1:0]  ack_q;
  logic [NUM_DRV-1:0]  tmo_q;
  logic                req_q;
  logic                abort_q;
  logic                busy_q;

  logic                found;
  logic [SCAN_W-1:0]   pick;
  int                  idx;
  logic                tmo_hit;
  logic [SCAN_W-1:0]   ptr_d;

  // Search starts at ptr and wraps explicitly, so non-power-of-two
  // drive counts never alias onto missing drives.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_DRV; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_DRV) idx = idx - NUM_DRV;
      if (!found && drvREQ[idx]) begin
        found = 1'b1;
        pick  = SCAN_W'(idx);
      end
    end
  end

  assign tmo_hit = (TIMEOUT != 0) && (timer_q == TMO_LAST);
  assign ptr_d   = (scan_q == LAST_DRV) ? '0 : scan_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      scan_q  <= '0;
      op_q    <= '0;
      lsa_q   <= '0;
      timer_q <= '0;
      ack_q   <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= !rst && (state_q == WAIT);
    end else begin
      ack_q   <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            scan_q  <= pick;
            op_q    <= drvSDOP[int'(pick)*OP_W +: OP_W];
            lsa_q   <= drvSDLSA[int'(pick)*LSA_W +: LSA_W];
            timer_q <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (timer_q != '1) timer_q <= timer_q + 1'b1;
          if (sdACK) begin
            ack_q[scan_q] <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= DONE;
          end else if (tmo_hit) begin
            ack_q[scan_q] <= 1'b1;
            tmo_q[scan_q] <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= ptr_d;
          timer_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drvACK  = ack_q;
  assign drvTMO  = tmo_q;
  assign sdREQ   = req_q;
  assign sdOP    = op_q;
  assign sdLSA   = lsa_q;
  assign sdSCAN  = scan_q;
  assign sdABORT = abort_q;
  assign arbBUSY = busy_q;

endmodule

// File: tb/tb_rp_sd_arbiter.sv
// Directed bench for rp_sd_arbiter: 8-drive build with short watchdog,
// plus a 5-drive build for pointer wrap.
module tb_rp_sd_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [7:0]    drvREQ = '0;
  logic [23:0]   drvSDOP = '0;
  logic [167:0]  drvSDLSA = '0;
  logic [7:0]    drvACK, drvTMO;
  logic          sdREQ, sdABORT, arbBUSY;
  logic [2:0]    sdOP, sdSCAN;
  logic [20:0]   sdLSA;
  logic          sdACK = 1'b0;

  logic [4:0]    req5 = '0;
  logic [14:0]   op5 = '0;
  logic [104:0]  lsa5 = '0;
  logic [4:0]    ack5, tmo5;
  logic          sdreq5, abort5, busy5;
  logic [2:0]    sdop5, scan5;
  logic [20:0]   sdlsa5;
  logic          sdack5 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rp_sd_arbiter #(.NUM_DRV(8), .TIMEOUT(16)) u8 (
    .clk(clk), .rst(rst), .clr(clr),
    .drvREQ(drvREQ), .drvSDOP(drvSDOP), .drvSDLSA(drvSDLSA),
    .drvACK(drvACK), .drvTMO(drvTMO),
    .sdREQ(sdREQ), .sdOP(sdOP), .sdLSA(sdLSA), .sdSCAN(sdSCAN),
    .sdACK(sdACK), .sdABORT(sdABORT), .arbBUSY(arbBUSY)
  );

  rp_sd_arbiter #(.NUM_DRV(5), .TIMEOUT(0)) u5 (
    .clk(clk), .rst(rst), .clr(clr),
    .drvREQ(req5), .drvSDOP(op5), .drvSDLSA(lsa5),
    .drvACK(ack5), .drvTMO(tmo5),
    .sdREQ(sdreq5), .sdOP(sdop5), .sdLSA(sdlsa5), .sdSCAN(scan5),
    .sdACK(sdack5), .sdABORT(abort5), .arbBUSY(busy5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1 reset with every request high
    drvREQ = 8'hFF;
    req5   = 5'h1F;
    tick();
    tick();
    chk("rst_sdREQ", {31'd0, sdREQ}, 32'd0);
    chk("rst_ack", {24'd0, drvACK}, 32'd0);
    chk("rst_tmo", {24'd0, drvTMO}, 32'd0);
    chk("rst_scan", {29'd0, sdSCAN}, 32'd0);
    chk("rst_op", {29'd0, sdOP}, 32'd0);
    chk("rst_lsa", {11'd0, sdLSA}, 32'd0);
    chk("rst_abort", {31'd0, sdABORT}, 32'd0);
    chk("rst_busy", {31'd0, arbBUSY}, 32'd0);
    chk("rst_req5", {31'd0, sdreq5}, 32'd0);
    rst    = 1'b0;
    drvREQ = '0;
    req5   = '0;
    tick();

    // 2 single request on drive 3
    drvREQ = 8'h08;
    drvSDOP[9 +: 3]    = 3'd2;
    drvSDLSA[63 +: 21] = 21'h1234;
    chk("s_pre_req", {31'd0, sdREQ}, 32'd0);
    tick();
    chk("s_req", {31'd0, sdREQ}, 32'd1);
    chk("s_scan", {29'd0, sdSCAN}, 32'd3);
    chk("s_op", {29'd0, sdOP}, 32'd2);
    chk("s_lsa", {11'd0, sdLSA}, 32'h1234);
    chk("s_busy", {31'd0, arbBUSY}, 32'd1);
    repeat (9) tick();
    chk("s_hold", {31'd0, sdREQ}, 32'd1);
    sdACK = 1'b1;
    tick();
    sdACK  = 1'b0;
    drvREQ = '0;
    chk("s_ack", {24'd0, drvACK}, 32'h08);
    chk("s_tmo", {24'd0, drvTMO}, 32'h00);
    chk("s_req_lo", {31'd0, sdREQ}, 32'd0);
    chk("s_done_busy", {31'd0, arbBUSY}, 32'd1);
    tick();
    chk("s_ack_1cyc", {24'd0, drvACK}, 32'h00);
    chk("s_idle_busy", {31'd0, arbBUSY}, 32'd0);

    // stray sdACK while idle
    sdACK = 1'b1;
    tick();
    sdACK = 1'b0;
    tick();
    chk("stray_ack", {24'd0, drvACK}, 32'h00);

    // 3 fairness from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drvREQ = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      if (g > 0) tick();
      chk($sformatf("rr_req%0d", g), {31'd0, sdREQ}, 32'd1);
      chk($sformatf("rr_scan%0d", g), {29'd0, sdSCAN}, g % 8);
      repeat (4) tick();
      sdACK = 1'b1;
      tick();
      sdACK = 1'b0;
      chk($sformatf("rr_ack%0d", g), {24'd0, drvACK}, 32'd1 << (g % 8));
    end
    drvREQ = '0;
    tick();
    tick();

    // 4 watchdog on drive 5 (pointer now 1)
    drvREQ = 8'h20;
    tick();
    chk("t_scan", {29'd0, sdSCAN}, 32'd5);
    repeat (15) tick();
    chk("t_early", {24'd0, drvACK}, 32'h00);
    chk("t_early_req", {31'd0, sdREQ}, 32'd1);
    tick();
    drvREQ = '0;
    chk("t_ack", {24'd0, drvACK}, 32'h20);
    chk("t_tmo", {24'd0, drvTMO}, 32'h20);
    chk("t_req_lo", {31'd0, sdREQ}, 32'd0);
    tick();
    chk("t_tmo_1cyc", {24'd0, drvTMO}, 32'h00);
    tick();
    drvREQ = 8'h20;
    tick();
    repeat (15) tick();
    sdACK = 1'b1;
    tick();
    sdACK  = 1'b0;
    drvREQ = '0;
    chk("t2_ack", {24'd0, drvACK}, 32'h20);
    chk("t2_tmo", {24'd0, drvTMO}, 32'h00);
    tick();
    tick();

    // 5 clear during WAIT (pointer 6, so drive 2 found after wrap)
    drvREQ = 8'h04;
    tick();
    chk("a_scan", {29'd0, sdSCAN}, 32'd2);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr    = 1'b0;
    drvREQ = 8'h05;
    chk("a_abort", {31'd0, sdABORT}, 32'd1);
    chk("a_req", {31'd0, sdREQ}, 32'd0);
    chk("a_ack", {24'd0, drvACK}, 32'h00);
    chk("a_busy", {31'd0, arbBUSY}, 32'd0);
    tick();
    chk("a_abort_1cyc", {31'd0, sdABORT}, 32'd0);
    chk("a_regrant", {29'd0, sdSCAN}, 32'd0);
    chk("a_regrant_req", {31'd0, sdREQ}, 32'd1);
    sdACK = 1'b1;
    tick();
    sdACK  = 1'b0;
    drvREQ = '0;
    chk("a_ack0", {24'd0, drvACK}, 32'h01);
    tick();
    tick();

    // 6 freeze of op/LSA during WAIT, drop of request mid-op
    drvREQ = 8'h04;
    drvSDOP[6 +: 3]    = 3'd5;
    drvSDLSA[42 +: 21] = 21'h0ABCDE;
    tick();
    chk("f_scan", {29'd0, sdSCAN}, 32'd2);
    chk("f_lsa", {11'd0, sdLSA}, 32'h0ABCDE);
    drvSDOP[6 +: 3]    = 3'd7;
    drvSDLSA[42 +: 21] = 21'h1FFFFF;
    drvREQ = '0;
    tick();
    tick();
    chk("f_lsa_frozen", {11'd0, sdLSA}, 32'h0ABCDE);
    chk("f_op_frozen", {29'd0, sdOP}, 32'd5);
    sdACK = 1'b1;
    tick();
    sdACK = 1'b0;
    chk("f_drop_ack", {24'd0, drvACK}, 32'h04);
    tick();
    tick();
    drvREQ = 8'h04;
    tick();
    chk("f_new_lsa", {11'd0, sdLSA}, 32'h1FFFFF);
    chk("f_new_op", {29'd0, sdOP}, 32'd7);
    drvREQ = '0;
    sdACK  = 1'b1;
    tick();
    sdACK = 1'b0;
    tick();
    tick();

    // clear while idle raises no abort
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c_idle_abort", {31'd0, sdABORT}, 32'd0);

    // 5-drive wrap, watchdog disabled
    req5 = 5'h1F;
    for (int g = 0; g < 6; g++) begin
      tick();
      if (g > 0) tick();
      chk($sformatf("w5_scan%0d", g), {29'd0, scan5}, g % 5);
      repeat ((g == 0) ? 30 : 2) tick();
      chk($sformatf("w5_noto%0d", g), {27'd0, ack5}, 32'd0);
      sdack5 = 1'b1;
      tick();
      sdack5 = 1'b0;
      chk($sformatf("w5_ack%0d", g), {27'd0, ack5}, 32'd1 << (g % 5));
      chk($sformatf("w5_tmo%0d", g), {27'd0, tmo5}, 32'd0);
    end
    req5 = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
